pulse_detector: RTL and testbench

PULSE_DETECTOR -- requirements
Module: pulse_detector

---
 rtl/pulse_detector_pkg.sv | 39 +++
 rtl/pulse_detector_event_out_reg.sv | 46 ++++
 rtl/pulse_detector.sv | 131 +++++++++++++
 tb/tb_pulse_detector.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pulse_detector_pkg.sv
// Shared types and constants for the pulse detector: FSM states, event-word
// layout, default thresholds and small datapath helpers.
package pulse_detector_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_e;

    localparam int SAMPLE_W  = 16;
    localparam int EVENT_W   = 32;
    localparam int PEAK_LSB  = 16;
    localparam int WIDTH_LSB = 0;

    localparam logic signed [15:0] DEF_HI_THRESH = 16'sd1000;
    localparam logic signed [15:0] DEF_LO_THRESH = 16'sd500;
    localparam logic        [15:0] DEF_MIN_WIDTH = 16'd4;

    function automatic logic [31:0] pack_event(input logic signed [15:0] peak,
                                               input logic        [15:0] width);
        logic [31:0] word;
        word = 32'd0;
        word[PEAK_LSB  +: SAMPLE_W] = peak;
        word[WIDTH_LSB +: SAMPLE_W] = width;
        return word;
    endfunction

    // Width counter sticks at all-ones instead of wrapping on very long pulses.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pulse_detector_event_out_reg.sv
// Single-entry output register holding one event word; loads and drains can
// coincide without a bubble.
module event_out_reg
    import pulse_detector_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [EVENT_W-1:0] load_data,
    input  logic               out_rdy,
    output logic [EVENT_W-1:0] out_data,
    output logic               out_vld
);

    logic [EVENT_W-1:0] data_q, data_d;
    logic               vld_q, vld_d;

    // Next-state of the holding register: load wins, else drain clears valid.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (load) begin
            data_d = load_data;
            vld_d  = 1'b1;
        end else if (vld_q && out_rdy) begin
            vld_d  = 1'b0;
        end else begin
            vld_d  = vld_q;
        end
    end

    // Holding register flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= {EVENT_W{1'b0}};
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign out_data = data_q;
    assign out_vld  = vld_q;

endmodule

// File: rtl/pulse_detector.sv
// Hysteresis pulse detector: tracks peak and width of pulses in a signed
// sample stream and emits {peak,width} for pulses at least MIN_WIDTH long.
module pulse_detector
    import pulse_detector_pkg::*;
#(
    parameter logic signed [15:0] HI_THRESH = DEF_HI_THRESH,
    parameter logic signed [15:0] LO_THRESH = DEF_LO_THRESH,
    parameter logic        [15:0] MIN_WIDTH = DEF_MIN_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pulse_detector__input_consumer,
    input  logic        pulse_detector__input_consumer_vld,
    output logic        pulse_detector__input_consumer_rdy,
    output logic [31:0] pulse_detector__output_producer,
    output logic        pulse_detector__output_producer_vld,
    input  logic        pulse_detector__output_producer_rdy
);

    state_e              state_q, state_d;
    logic signed [15:0]  peak_q, peak_d;
    logic        [15:0]  width_q, width_d;
    logic signed [15:0]  sample_s;
    logic                in_xfer_s;
    logic                emit_s;
    logic        [31:0]  event_s;
    logic                out_vld_s;

    assign sample_s  = pulse_detector__input_consumer;
    assign pulse_detector__input_consumer_rdy = pulse_detector__input_consumer_vld & ~reset &
                                                (~out_vld_s | pulse_detector__output_producer_rdy);
    assign in_xfer_s = pulse_detector__input_consumer_vld & pulse_detector__input_consumer_rdy;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; only an accepted sample moves the FSM.
    always_comb begin
        state_d = state_q;
        if (in_xfer_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (sample_s >= HI_THRESH) state_d = ST_PULSE;
                    else                       state_d = ST_IDLE;
                end
                ST_PULSE: begin
                    if (sample_s < LO_THRESH) state_d = ST_IDLE;
                    else                      state_d = ST_PULSE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Peak/width tracking; the terminating sample contributes to neither.
    always_comb begin
        peak_d  = peak_q;
        width_d = width_q;
        if (in_xfer_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (sample_s >= HI_THRESH) begin
                        peak_d  = sample_s;
                        width_d = 16'd1;
                    end else begin
                        peak_d  = peak_q;
                    end
                end
                ST_PULSE: begin
                    if (sample_s >= LO_THRESH) begin
                        width_d = sat_inc(width_q);
                        if (sample_s > peak_q) peak_d = sample_s;
                        else                   peak_d = peak_q;
                    end else begin
                        width_d = width_q;
                    end
                end
                default: begin
                    peak_d  = 16'sd0;
                    width_d = 16'd0;
                end
            endcase
        end else begin
            width_d = width_q;
        end
    end

    // Peak and width registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q  <= 16'sd0;
            width_q <= 16'd0;
        end else begin
            peak_q  <= peak_d;
            width_q <= width_d;
        end
    end

    // FSM output logic: emit on the terminating sample of a long-enough pulse.
    always_comb begin
        emit_s  = 1'b0;
        event_s = pack_event(peak_q, width_q);
        if (in_xfer_s && (state_q == ST_PULSE) && (sample_s < LO_THRESH) &&
            (width_q >= MIN_WIDTH)) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
    end

    event_out_reg u_event_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (emit_s),
        .load_data (event_s),
        .out_rdy   (pulse_detector__output_producer_rdy),
        .out_data  (pulse_detector__output_producer),
        .out_vld   (out_vld_s)
    );

    assign pulse_detector__output_producer_vld = out_vld_s;

endmodule

// File: tb/tb_pulse_detector.sv
// Directed bench for pulse_detector: expected event words are queued when the
// terminating sample is driven and compared as the output channel transfers.
module tb_pulse_detector;
    import pulse_detector_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] out_data;
    logic        out_vld;
    logic        out_rdy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] held;

    always #5 clk = ~clk;

    pulse_detector dut (
        .clk                                 (clk),
        .reset                               (reset),
        .pulse_detector__input_consumer      (in_data),
        .pulse_detector__input_consumer_vld  (in_vld),
        .pulse_detector__input_consumer_rdy  (in_rdy),
        .pulse_detector__output_producer     (out_data),
        .pulse_detector__output_producer_vld (out_vld),
        .pulse_detector__output_producer_rdy (out_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Output monitor: every output transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_vld === 1'b1 && out_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", out_data, 32'hDEAD_BEEF);
            end else begin
                chk("event_word", out_data, exp_q.pop_front());
            end
        end
    end

    // Drive one sample and return #1 after the edge on which it transferred.
    task automatic send(input logic signed [15:0] s);
        int n;
        n = 0;
        in_data = s;
        in_vld  = 1'b1;
        @(negedge clk);
        while (in_rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("input_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        in_data = 16'd0;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        idle(2);
        in_vld = 1'b1;
        #1;
        chk("reset_out_vld", {31'd0, out_vld}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_in_rdy", {31'd0, in_rdy}, 32'd0);
        chk("reset_state", {31'd0, dut.state_q}, {31'd0, ST_IDLE});
        in_vld = 1'b0;
        reset  = 1'b0;
        idle(1);

        // Basic pulse: peak 1500, width 4, event one cycle after the 400.
        send(16'sd0); send(16'sd1200); send(16'sd1500); send(16'sd1100); send(16'sd900);
        exp_q.push_back(32'h05DC_0004);
        send(16'sd400);
        chk("basic_latency_vld", {31'd0, out_vld}, 32'd1);
        chk("basic_latency_data", out_data, 32'h05DC_0004);
        idle(3);
        chk("basic_single_event", {31'd0, out_vld}, 32'd0);

        // Short pulse is discarded.
        send(16'sd0); send(16'sd1200); send(16'sd1300); send(16'sd400);
        idle(3);
        chk("short_no_event", {31'd0, out_vld}, 32'd0);
        chk("short_state_idle", {31'd0, dut.state_q}, {31'd0, ST_IDLE});

        // Inclusive threshold boundaries.
        send(16'sd1000); send(16'sd500); send(16'sd500); send(16'sd500);
        exp_q.push_back(32'h03E8_0004);
        send(16'sd499);
        idle(3);

        // Output back-pressure: event held, input blocked.
        out_rdy = 1'b0;
        send(16'sd0); send(16'sd1200); send(16'sd1500); send(16'sd1100); send(16'sd900);
        exp_q.push_back(32'h05DC_0004);
        send(16'sd400);
        held    = out_data;
        in_data = 16'd0;
        in_vld  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_vld", {31'd0, out_vld}, 32'd1);
            chk("stall_data", out_data, 32'h05DC_0004);
            chk("stall_in_rdy", {31'd0, in_rdy}, 32'd0);
        end
        chk("stall_data_stable", out_data, held);
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        #1;
        chk("resume_in_rdy", {31'd0, in_rdy}, 32'd1);
        send(16'sd0);
        idle(2);
        chk("stall_once", {31'd0, out_vld}, 32'd0);
        chk("stall_drained", exp_q.size(), 32'd0);

        // Width saturation on a very long pulse.
        for (int i = 0; i < 70000; i++) send(16'sd2000);
        exp_q.push_back(32'h07D0_FFFF);
        send(16'sd0);
        idle(3);

        // Reset mid-pulse discards the pulse; a transfer offered during reset is ignored.
        send(16'sd1200); send(16'sd1300);
        reset   = 1'b1;
        in_data = 16'sd1500;
        in_vld  = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_out_vld", {31'd0, out_vld}, 32'd0);
        chk("midreset_out_data", out_data, 32'd0);
        chk("midreset_in_rdy", {31'd0, in_rdy}, 32'd0);
        chk("midreset_width", {16'd0, dut.width_q}, 32'd0);
        reset  = 1'b0;
        in_vld = 1'b0;
        send(16'sd1500); send(16'sd1500); send(16'sd1500); send(16'sd1500);
        exp_q.push_back(32'h05DC_0004);
        send(16'sd0);
        idle(4);

        chk("all_events_seen", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
